stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/sync_edge.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared types and defaults for the stopwatch control block:
//            the 2-bit FSM state enum, its encodings and the default
//            long-press length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned LONG_CYCLES_DEFAULT = 100000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ADJUST = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Brings one asynchronous level into the clk domain through a
//            SYNC_STAGES-deep flop chain and produces a registered one-cycle
//            rising-edge pulse from the synchronized level.
// Ports    : clk     - clock
//            rst_n   - asynchronous active-low reset
//            d_i     - asynchronous input level
//            level_o - synchronized level (last chain stage)
//            edge_o  - registered rising-edge pulse, SYNC_STAGES+1 edges
//                      after the first edge that samples d_i high
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      // prev_q lags the synchronized level by one cycle, so a held level
      // yields a single pulse.
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign edge_o  = edge_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Control FSM for a stopwatch. Synchronizes four button/switch
//            inputs, detects their rising edges and sequences the
//            IDLE / RUN / PAUSED / ADJUST states. All outputs are registered.
// Config   : STOPWATCH_LONG_PRESS_EN - when defined, holding pause for
//            LONG_CYCLES consecutive cycles while PAUSED acts as a clear.
// Ports    : clk       - clock
//            rst_n     - asynchronous active-low reset
//            clr_in    - clear button level (async)
//            pause_in  - pause button level (async)
//            adj_in    - adjust switch level (async)
//            sel_in    - select switch/button level (async)
//            run       - high while counting
//            clr_pulse - one-cycle command to zero the counters
//            adj_mode  - high while in ADJUST
//            sel_sec   - adjust target, 1 = seconds, 0 = minutes
//            state_o   - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_in,
  input  logic       pause_in,
  input  logic       adj_in,
  input  logic       sel_in,
  output logic       run,
  output logic       clr_pulse,
  output logic       adj_mode,
  output logic       sel_sec,
  output logic [1:0] state_o
);

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detectors
  // --------------------------------------------------------------------------
  logic clr_lvl, clr_edge;
  logic pause_lvl, pause_edge;
  logic adj_lvl, adj_edge;
  logic sel_lvl, sel_edge;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .rst_n(rst_n), .d_i(clr_in),
    .level_o(clr_lvl), .edge_o(clr_edge)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pause (
    .clk(clk), .rst_n(rst_n), .d_i(pause_in),
    .level_o(pause_lvl), .edge_o(pause_edge)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adj (
    .clk(clk), .rst_n(rst_n), .d_i(adj_in),
    .level_o(adj_lvl), .edge_o(adj_edge)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .rst_n(rst_n), .d_i(sel_in),
    .level_o(sel_lvl), .edge_o(sel_edge)
  );

  state_e state_q, state_d;
  logic   lp_fire;

  // --------------------------------------------------------------------------
  // Optional long-press clear
  // --------------------------------------------------------------------------
`ifdef STOPWATCH_LONG_PRESS_EN
  localparam int unsigned      LP_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [LP_W-1:0]  LP_MAX  = LP_W'(LONG_CYCLES);
  localparam logic [LP_W-1:0]  LP_LAST = LP_W'(LONG_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
  logic            lp_hold;

  assign lp_hold = (state_q == ST_PAUSED) && pause_lvl;

  always_comb begin
    lp_cnt_d = lp_cnt_q;
    if (!lp_hold) begin
      lp_cnt_d = '0;
    end else if (lp_cnt_q != LP_MAX) begin
      lp_cnt_d = lp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_cnt_q <= '0;
    end else begin
      lp_cnt_q <= lp_cnt_d;
    end
  end

  // Fires on the LONG_CYCLES-th held cycle. Firing leaves PAUSED, which
  // clears the counter, so one hold can only fire once.
  assign lp_fire = lp_hold && (lp_cnt_q == LP_LAST);

  logic unused_lvls;
  assign unused_lvls = ^{clr_lvl, sel_lvl, adj_edge};
`else
  assign lp_fire = 1'b0;

  // LONG_CYCLES only matters when long press is built in.
  logic unused_lvls;
  assign unused_lvls = ^{clr_lvl, sel_lvl, adj_edge, pause_lvl, 1'(LONG_CYCLES)};
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Clear beats everything; adj is a level, so an adj held
  // through a clear re-enters ADJUST on the following cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clr_edge || lp_fire) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (adj_lvl)         state_d = ST_ADJUST;
          else if (pause_edge) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause_edge)      state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (adj_lvl)         state_d = ST_ADJUST;
          else if (pause_edge) state_d = ST_RUN;
        end
        ST_ADJUST: begin
          if (!adj_lvl)        state_d = ST_PAUSED;
        end
        default:               state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output next values, decoded from the next state so the registered
  // outputs line up with state_q.
  // --------------------------------------------------------------------------
  logic run_q, run_d;
  logic clr_pulse_q, clr_pulse_d;
  logic adj_mode_q, adj_mode_d;
  logic sel_sec_q, sel_sec_d;

  always_comb begin
    run_d       = (state_d == ST_RUN);
    adj_mode_d  = (state_d == ST_ADJUST);
    clr_pulse_d = clr_edge | lp_fire;
    sel_sec_d   = sel_sec_q;
    if ((state_q == ST_ADJUST) && sel_edge) begin
      sel_sec_d = ~sel_sec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      clr_pulse_q <= 1'b0;
      adj_mode_q  <= 1'b0;
      sel_sec_q   <= 1'b1;
    end else begin
      run_q       <= run_d;
      clr_pulse_q <= clr_pulse_d;
      adj_mode_q  <= adj_mode_d;
      sel_sec_q   <= sel_sec_d;
    end
  end

  assign run       = run_q;
  assign clr_pulse = clr_pulse_q;
  assign adj_mode  = adj_mode_q;
  assign sel_sec   = sel_sec_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed self-checking bench for stopwatch_ctrl with
//            SYNC_STAGES=2 and LONG_CYCLES=50. Inputs change 1 time unit
//            after a rising edge; outputs are checked at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int unsigned LC = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_in, pause_in, adj_in, sel_in;
  logic       run, clr_pulse, adj_mode, sel_sec;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;
  int clr_cnt  = 0;
  int c0;

  stopwatch_ctrl #(.SYNC_STAGES(2), .LONG_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n),
    .clr_in(clr_in), .pause_in(pause_in), .adj_in(adj_in), .sel_in(sel_in),
    .run(run), .clr_pulse(clr_pulse), .adj_mode(adj_mode),
    .sel_sec(sel_sec), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Counts clr_pulse cycles, sampled mid-cycle.
  always @(negedge clk) if (clr_pulse === 1'b1) clr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0=clr 1=pause 2=sel ; two-cycle press then settle
  task automatic press(input int which);
    case (which)
      0: clr_in = 1'b1;
      1: pause_in = 1'b1;
      default: sel_in = 1'b1;
    endcase
    step(2);
    clr_in = 1'b0; pause_in = 1'b0; sel_in = 1'b0;
    step(4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clr_in = 1'b0; pause_in = 1'b0; adj_in = 1'b0; sel_in = 1'b0;
    step(2);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_run", 32'(run), 0);
    chk("rst_clr", 32'(clr_pulse), 0);
    chk("rst_adj", 32'(adj_mode), 0);
    chk("rst_sel", 32'(sel_sec), 1);
    rst_n = 1'b1;
    step(2);

    // pause held 20 cycles: run rises after exactly 3 more edges, once
    pause_in = 1'b1;
    step(3);
    chk("run_lat_early", 32'(run), 0);
    step(1);
    chk("run_lat", 32'(run), 1);
    chk("run_state", 32'(state_o), 1);
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("run_hold", 32'(state_o), 1);
    end
    pause_in = 1'b0;
    step(3);

    // clr and pause together in RUN: clr wins
    c0 = clr_cnt;
    clr_in = 1'b1; pause_in = 1'b1;
    step(3);
    chk("clrp_pre", 32'(state_o), 1);
    step(1);
    chk("clrp_state", 32'(state_o), 0);
    chk("clrp_pulse", 32'(clr_pulse), 1);
    chk("clrp_run", 32'(run), 0);
    step(1);
    chk("clrp_pulse_end", 32'(clr_pulse), 0);
    step(3);
    chk("clrp_stay", 32'(state_o), 0);
    clr_in = 1'b0; pause_in = 1'b0;
    step(3);
    chk("clrp_count", 32'(clr_cnt - c0), 1);

    // PAUSED -> ADJUST, sel toggles, pause ignored, back to PAUSED
    press(1);
    chk("to_run", 32'(state_o), 1);
    press(1);
    chk("to_paused", 32'(state_o), 2);
    adj_in = 1'b1;
    step(2);
    chk("adj_pre", 32'(state_o), 2);
    step(1);
    chk("adj_state", 32'(state_o), 3);
    chk("adj_mode", 32'(adj_mode), 1);
    press(2);
    chk("sel_t1", 32'(sel_sec), 0);
    press(1);
    chk("adj_pause_ign", 32'(state_o), 3);
    press(2);
    chk("sel_t2", 32'(sel_sec), 1);
    adj_in = 1'b0;
    step(2);
    chk("adj_exit_pre", 32'(state_o), 3);
    step(1);
    chk("adj_exit", 32'(state_o), 2);
    chk("adj_mode_off", 32'(adj_mode), 0);

    // adj in RUN ignored; pause edge -> PAUSED then ADJUST next cycle
    press(1);
    chk("run2", 32'(state_o), 1);
    adj_in = 1'b1;
    step(5);
    chk("run_adj_ign", 32'(state_o), 1);
    chk("run_adj_mode", 32'(adj_mode), 0);
    pause_in = 1'b1;
    step(4);
    chk("run_to_paused", 32'(state_o), 2);
    step(1);
    chk("paused_to_adj", 32'(state_o), 3);
    pause_in = 1'b0;
    step(3);
    adj_in = 1'b0;
    step(3);
    chk("adj_off2", 32'(state_o), 2);

    // clr edge together with adj level: IDLE then ADJUST
    clr_in = 1'b1;
    step(1);
    adj_in = 1'b1;
    step(2);
    chk("ca_pre", 32'(state_o), 3 - 1);
    step(1);
    chk("ca_idle", 32'(state_o), 0);
    chk("ca_pulse", 32'(clr_pulse), 1);
    step(1);
    chk("ca_adj", 32'(state_o), 3);
    chk("ca_pulse_end", 32'(clr_pulse), 0);
    clr_in = 1'b0; adj_in = 1'b0;
    step(3);
    chk("ca_paused", 32'(state_o), 2);

    // back-to-back clr edges give separate one-cycle pulses
    clr_in = 1'b1; step(1);
    clr_in = 1'b0; step(1);
    clr_in = 1'b1; step(1);
    clr_in = 1'b0; step(1);
    chk("b2b_p1", 32'(clr_pulse), 1);
    step(1);
    chk("b2b_gap", 32'(clr_pulse), 0);
    step(1);
    chk("b2b_p2", 32'(clr_pulse), 1);
    step(1);
    chk("b2b_end", 32'(clr_pulse), 0);
    chk("b2b_state", 32'(state_o), 0);

    // sel ignored outside ADJUST
    press(2);
    chk("sel_idle_ign", 32'(sel_sec), 1);
    press(1);
    press(2);
    chk("sel_run_ign", 32'(sel_sec), 1);
    chk("sel_run_state", 32'(state_o), 1);

    // asynchronous reset mid-RUN, pause held through release
    #2;
    rst_n = 1'b0;
    pause_in = 1'b1;
    #1;
    chk("arst_run", 32'(run), 0);
    chk("arst_state", 32'(state_o), 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("rel_early", 32'(run), 0);
    step(1);
    chk("rel_run", 32'(run), 1);
    step(5);
    chk("rel_once", 32'(state_o), 1);
    pause_in = 1'b0;
    step(3);

`ifdef STOPWATCH_LONG_PRESS_EN
    // short hold in PAUSED: no clear
    c0 = clr_cnt;
    pause_in = 1'b1;
    step(40);
    pause_in = 1'b0;
    step(5);
    chk("lp_short_state", 32'(state_o), 2);
    chk("lp_short_cnt", 32'(clr_cnt - c0), 0);
    press(1);
    chk("lp_run", 32'(state_o), 1);
    // long hold: PAUSED after 4 edges, 50th held PAUSED cycle fires at edge 54
    c0 = clr_cnt;
    pause_in = 1'b1;
    step(53);
    chk("lp_pre_state", 32'(state_o), 2);
    chk("lp_pre_pulse", 32'(clr_pulse), 0);
    step(1);
    chk("lp_fire_state", 32'(state_o), 0);
    chk("lp_fire_pulse", 32'(clr_pulse), 1);
    step(1);
    chk("lp_pulse_end", 32'(clr_pulse), 0);
    step(10);
    chk("lp_idle", 32'(state_o), 0);
    chk("lp_once", 32'(clr_cnt - c0), 1);
    pause_in = 1'b0;
    step(3);
`else
    // without long press a long hold in PAUSED does nothing
    c0 = clr_cnt;
    pause_in = 1'b1;
    step(64);
    chk("nolp_state", 32'(state_o), 2);
    chk("nolp_cnt", 32'(clr_cnt - c0), 0);
    pause_in = 1'b0;
    step(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
